// File: rtl/block_ram_pkg.sv
// Shared types and helpers for the dual-port block RAM and its clear sequencer.
// Byte parity helpers are used only when BLOCK_RAM_PARITY_EN is defined.
package block_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Widest word byteParity accepts; callers zero-extend and keep the low lanes.
    localparam int PAR_MAX_W     = 1024;
    localparam int PAR_MAX_BYTES = PAR_MAX_W / 8;

    function automatic int bytes(input int width);
        return width / 8;
    endfunction

    function automatic logic [PAR_MAX_BYTES-1:0] byteParity(input logic [PAR_MAX_W-1:0] data);
        logic [PAR_MAX_BYTES-1:0] par;
        for (int i = 0; i < PAR_MAX_BYTES; i++) begin
            par[i] = ^data[i*8 +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/block_ram_clear_fsm.sv
// Clear sequencer: walks every address once, driving a zero write per cycle,
// and pulses clrDone as busy falls.
module block_ram_clear_fsm
    import block_ram_pkg::*;
#(
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  clrStart,
    output logic                  busy,
    output logic                  clrDone,
    output logic                  clrWrEn,
    output logic [ADDR_WIDTH-1:0] clrAddr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    clr_state_t            state_reg;
    logic [ADDR_WIDTH-1:0] count_reg;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_reg <= IDLE;
            count_reg <= '0;
            busy      <= 1'b0;
            clrDone   <= 1'b0;
        end else begin
            clrDone <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clrStart) begin
                        state_reg <= CLEAR;
                        count_reg <= '0;
                        busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (count_reg == LAST_ADDR) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        clrDone   <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign clrWrEn = (state_reg == CLEAR);
    assign clrAddr = count_reg;

endmodule

// File: rtl/block_ram_dp.sv
// Simple-dual-port byte-enabled RAM with write-first bypass, optional output register
// and hardware clear. Define BLOCK_RAM_PARITY_EN to store and check per-byte parity.
module block_ram_dp
    import block_ram_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    MEM_DEPTH  = 1024,
    parameter int    ADDR_WIDTH = 10,
    parameter string INIT_FILE  = "meminit.data",
    parameter int    OUT_REG    = 0
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic                    wrEn,
    input  logic [ADDR_WIDTH-1:0]   wrAddr,
    input  logic [DATA_WIDTH-1:0]   wrData,
    input  logic [DATA_WIDTH/8-1:0] wrByteEn,
    input  logic                    rdReq,
    input  logic [ADDR_WIDTH-1:0]   rdAddr,
    output logic                    rdValid,
    output logic [DATA_WIDTH-1:0]   rdData,
    output logic                    rdParErr,
    input  logic                    clrStart,
    output logic                    busy,
    output logic                    clrDone
);

    localparam int NB = bytes(DATA_WIDTH);
`ifdef BLOCK_RAM_PARITY_EN
    localparam int STORE_W = DATA_WIDTH + NB;
`else
    localparam int STORE_W = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    // Stored word layout: {parity lanes (parity build only), data}
    logic [STORE_W-1:0] mem [MEM_DEPTH];

    logic                  clr_wr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;

    block_ram_clear_fsm #(
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .clock    (clock),
        .resetN   (resetN),
        .clrStart (clrStart),
        .busy     (busy),
        .clrDone  (clrDone),
        .clrWrEn  (clr_wr_en),
        .clrAddr  (clr_addr)
    );

`ifdef BLOCK_RAM_PARITY_EN
    function automatic logic [NB-1:0] lane_parity(input logic [DATA_WIDTH-1:0] d);
        logic [PAR_MAX_BYTES-1:0] p;
        p = byteParity(PAR_MAX_W'(d));
        return p[NB-1:0];
    endfunction
`endif

    // Write port: the clear sequencer owns the array while busy
    logic                  wr_user;
    logic                  wr_go;
    logic [ADDR_WIDTH-1:0] wr_addr_eff;
    logic [DATA_WIDTH-1:0] wr_data_eff;
    logic [NB-1:0]         wr_be_eff;

    assign wr_user = wrEn && !busy && ({1'b0, wrAddr} < DEPTH_LIM);

    always_comb begin
        wr_go       = wr_user;
        wr_addr_eff = wrAddr;
        wr_data_eff = wrData;
        wr_be_eff   = wrByteEn;
        if (clr_wr_en) begin
            wr_go       = 1'b1;
            wr_addr_eff = clr_addr;
            wr_data_eff = '0;
            wr_be_eff   = '1;
        end
    end

`ifdef BLOCK_RAM_PARITY_EN
    logic [NB-1:0] wr_par;
    assign wr_par = lane_parity(wr_data_eff);
`endif

    always_ff @(posedge clock) begin
        if (wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be_eff[i]) begin
                    mem[wr_addr_eff][i*8 +: 8] <= wr_data_eff[i*8 +: 8];
`ifdef BLOCK_RAM_PARITY_EN
                    mem[wr_addr_eff][DATA_WIDTH + i] <= wr_par[i];
`endif
                end
            end
        end
    end

    // Read port with write-first merge of enabled bytes on an address match
    logic                  rd_fire;
    logic                  rd_hit;
    logic [STORE_W-1:0]    rd_raw;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_err;

    assign rd_fire = rdReq && !busy;
    assign rd_hit  = wr_user && (wrAddr == rdAddr);
    assign rd_raw  = ({1'b0, rdAddr} < DEPTH_LIM) ? mem[rdAddr] : '0;

`ifdef BLOCK_RAM_PARITY_EN
    logic [NB-1:0] rd_par;
`endif

    always_comb begin
        rd_word = rd_raw[DATA_WIDTH-1:0];
`ifdef BLOCK_RAM_PARITY_EN
        rd_par  = rd_raw[DATA_WIDTH +: NB];
`endif
        for (int i = 0; i < NB; i++) begin
            if (rd_hit && wrByteEn[i]) begin
                rd_word[i*8 +: 8] = wrData[i*8 +: 8];
`ifdef BLOCK_RAM_PARITY_EN
                rd_par[i] = wr_par[i];
`endif
            end
        end
`ifdef BLOCK_RAM_PARITY_EN
        rd_err = |(rd_par ^ lane_parity(rd_word));
`else
        rd_err = 1'b0;
`endif
    end

    logic                  rd_valid_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_err_reg;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            rd_err_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= rd_fire;
            if (rd_fire) begin
                rd_data_reg <= rd_word;
                rd_err_reg  <= rd_err;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  out_valid_reg;
        logic [DATA_WIDTH-1:0] out_data_reg;
        logic                  out_err_reg;

        always_ff @(posedge clock or negedge resetN) begin
            if (!resetN) begin
                out_valid_reg <= 1'b0;
                out_data_reg  <= '0;
                out_err_reg   <= 1'b0;
            end else begin
                out_valid_reg <= rd_valid_reg;
                if (rd_valid_reg) begin
                    out_data_reg <= rd_data_reg;
                    out_err_reg  <= rd_err_reg;
                end
            end
        end

        assign rdValid  = out_valid_reg;
        assign rdData   = out_data_reg;
        assign rdParErr = out_err_reg;
    end else begin : g_out_direct
        assign rdValid  = rd_valid_reg;
        assign rdData   = rd_data_reg;
        assign rdParErr = rd_err_reg;
    end

endmodule
